// File: rtl/pipe_stage_buf_if.sv
// Handshake, payload and side-state bundle between two pipeline stages.
// master = upstream/downstream environment, slave = the stage buffer.
interface pipe_stage_buf_if #(
  parameter int DATA_W  = 160,
  parameter int STATE_W = 66
) ();
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               in_hold;
  logic [STATE_W-1:0] state_i;
  logic [STATE_W-1:0] state_o;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [1:0]         count;

  modport master (
    output flush, in_valid, in_data, in_hold, state_i, out_ready,
    input  in_ready, state_o, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, in_hold, state_i, out_ready,
    output in_ready, state_o, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with optional skid entry and a held side state.
// Latency 1 cycle; SKID=1 gives registered in_ready, SKID=0 combinational in_ready.
module pipe_stage_buf #(
  parameter int          DATA_W  = 160,
  parameter int          STATE_W = 66,
  parameter int unsigned SKID    = 1
) (
  input  logic            clk,
  input  logic            rst,
  pipe_stage_buf_if.slave bus
);

  logic               main_vld_q, main_vld_d;
  logic [DATA_W-1:0]  main_dat_q, main_dat_d;
  logic               skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0]  skid_dat_q, skid_dat_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               rdy_q, rdy_d;
  logic               in_rdy;
  logic               acc;
  logic               rel;

  always_comb begin
    if (SKID != 0) begin
      in_rdy = rdy_q && !bus.flush;
    end else begin
      in_rdy = !bus.flush && (!main_vld_q || bus.out_ready);
    end
    acc = bus.in_valid && in_rdy;
    rel = main_vld_q && bus.out_ready;
  end

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    rdy_d      = rdy_q;
    state_d    = (!bus.flush && bus.in_hold) ? bus.state_i : '0;

    if (bus.flush) begin
      main_vld_d = 1'b0;
      main_dat_d = '0;
      skid_vld_d = 1'b0;
      skid_dat_d = '0;
      rdy_d      = 1'b1;
    end else begin
      // Release first: either promote the skid entry or leave a zeroed bubble.
      if (rel) begin
        if (skid_vld_q) begin
          main_vld_d = 1'b1;
          main_dat_d = skid_dat_q;
          skid_vld_d = 1'b0;
          skid_dat_d = '0;
        end else begin
          main_vld_d = 1'b0;
          main_dat_d = '0;
        end
      end
      // An accept only happens with the skid empty, so main is free if empty or releasing.
      if (acc) begin
        if (!main_vld_q || rel) begin
          main_vld_d = 1'b1;
          main_dat_d = bus.in_data;
        end else if (SKID != 0) begin
          skid_vld_d = 1'b1;
          skid_dat_d = bus.in_data;
        end
      end
      rdy_d = !skid_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      state_q    <= '0;
      rdy_q      <= 1'b1;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      state_q    <= state_d;
      rdy_q      <= rdy_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = main_vld_q;
  assign bus.out_data  = main_vld_q ? main_dat_q : '0;
  assign bus.state_o   = state_q;
  assign bus.count     = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline register, the next generation of the EX/MEM-style stage latch. It replaces the fixed-field, stall-vector-driven latch with a generic payload bus, a valid/ready handshake and an optional skid entry. It also carries a multi-cycle side state, such as the HI/LO accumulator plus step count for MADD/MSUB. One instance sits between each pair of pipeline stages (ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, default 160: payload width (pc, wd, wreg, wdata, hi, lo, aluop, addr, cp0 fields, excepttype, …, packed by the instantiating stage).
- STATE_W, default 66: side-state width (64-bit hilo + 2-bit cnt).
- SKID, default 1: 1 = two-entry buffer with registered in_ready; 0 = single register with combinational in_ready.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  exception/ERET flush; discards all held entries and side state.
- in_valid  in  1  upstream stage has a completed instruction.
- in_ready  out  1  buffer accepts in_data this cycle.
- in_data  in  DATA_W  upstream payload.
- in_hold  in  1  upstream is mid multi-cycle operation and stalled.
- state_i  in  STATE_W  upstream partial result.
- state_o  out  STATE_W  partial result returned to upstream next cycle.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes head this cycle.
- out_data  out  DATA_W  head payload; all-zero whenever out_valid=0.
- count  out  2  occupancy, 0..2 (max 1 when SKID=0).

## Operation
- Accept: in_valid && in_ready. Release: out_valid && out_ready.
- Entries:
  - main register drives out_*.
  - skid register exists only when SKID=1.
- SKID=1:
  - in_ready = !skid_valid, registered.
  - Accept with main empty, or main releasing with skid empty: load main.
  - Accept with main full and not releasing: load skid.
  - Release with skid full: skid moves to main; skid cleared.
  - A simultaneous release and accept with skid empty loads main directly.
- SKID=0:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept loads main.
- Bubble rule: release with no replacement sets out_valid=0 and zeroes out_data. Downstream then sees a NOP with all write-enables low.
- Side state: state_o <= state_i when in_hold=1; otherwise state_o <= 0. This is independent of handshake, so the accumulator survives any downstream stall.
- flush (priority below rst, above everything else):
  - main and skid invalid, out_data=0, state_o=0, count=0.
  - in_ready forced 0 in the flush cycle, so no accept.
- Payload is never modified. Zeroing occurs only on an invalid entry.

## Timing
- Reset values: out_valid=0, out_data=0, state_o=0, count=0. in_ready=1 from the first cycle after reset (both modes), provided flush=0.
- Latency in→out: 1 cycle (accepted at edge N, visible after edge N).
- Throughput: 1 per cycle with out_ready held 1.
- SKID=1: in_ready falls the cycle after the skid loads. It rises the cycle after the skid drains.
- Empty buffer with out_ready=0: the accept still happens. The head is held until out_ready.
- Full (count=2): in_valid is ignored. in_data need not be stable.
- rst or flush during a skid-full stall: next cycle count=0, in_ready=1.
- in_hold with flush: flush wins; state_o=0.
- count never exceeds 2. No wrap.

## Test plan
- Stream: SKID=1, out_ready=1, feed payloads 1..8 back-to-back → out_data 1..8 on consecutive cycles one cycle later; count stays 1; in_ready stays 1.
- Backpressure: send A,B,C; drop out_ready after A is visible → A held; B lands in the skid; in_ready=0; C is not accepted. Raise out_ready → A, B, C delivered in order, no loss or duplication.
- Bubble: single payload 0x5, then in_valid=0 → after release out_valid=0 and out_data=0.
- Side state: in_hold=1 for 3 cycles with state_i=0x1_0000_0000_0000_0002 while out_ready=0 → state_o tracks state_i one cycle later. Drop in_hold → state_o=0 next cycle.
- Flush: count=2, state_o≠0, assert flush with in_valid=1 → next cycle count=0, out_valid=0, out_data=0, state_o=0; the flush-cycle payload is never output.
- SKID=0: out_ready=0 with head valid → in_ready=0 combinationally. Accept and release on the same cycle keep count=1.
